// File: rtl/pc_next_unit.sv
// Program-counter unit for the single-cycle RV32I core: next-PC select,
// misaligned-target trap redirect, retired-instruction counter and debug halt.
module pc_next_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            PC_SRC,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            halt_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] mepc,
    output logic            mis_trap,
    output logic [1:0]      state,
    output logic [XLEN-1:0] instret
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        TRAP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_d, mepc_d, instret_d;
    logic            mis_trap_d;

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] target;
    logic            misaligned;

    assign pc_plus4 = pc + XLEN'(4);
    assign pc_imm   = pc + imm;
    assign jalr_sum = rs1_val + imm;
    assign state    = state_q;

    // Next-PC select: JALR beats JAL beats taken branch beats sequential.
    always_comb begin
        target = pc_plus4;
        if (jalr) begin
            target = jalr_sum & ~XLEN'(1);
        end else if (jal || PC_SRC) begin
            target = pc_imm;
        end
        misaligned = target[1];
    end

    // Next-state and register updates; en=0 leaves every register as is.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        mepc_d     = mepc;
        instret_d  = instret;
        mis_trap_d = mis_trap;
        if (en) begin
            mis_trap_d = 1'b0;
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (misaligned) begin
                        mepc_d     = pc;
                        pc_d       = TRAP_VECTOR;
                        state_d    = TRAP;
                        mis_trap_d = 1'b1;
                    end else if (halt_req) begin
                        state_d = HALTED;
                    end else begin
                        pc_d      = target;
                        instret_d = instret + XLEN'(1);
                    end
                end
                TRAP: begin
                    state_d = RUN;
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc       <= RESET_VECTOR;
            mepc     <= '0;
            instret  <= '0;
            mis_trap <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            mepc     <= mepc_d;
            instret  <= instret_d;
            mis_trap <= mis_trap_d;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        PC_SRC;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] mepc;
    logic        mis_trap;
    logic [1:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int passed = 0;

    pc_next_unit #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .PC_SRC  (PC_SRC),
        .jal     (jal),
        .jalr    (jalr),
        .imm     (imm),
        .rs1_val (rs1_val),
        .halt_req(halt_req),
        .pc      (pc),
        .pc_plus4(pc_plus4),
        .mepc    (mepc),
        .mis_trap(mis_trap),
        .state   (state),
        .instret (instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PC_SRC   = 1'b0;
        jal      = 1'b0;
        jalr     = 1'b0;
        imm      = '0;
        rs1_val  = '0;
        halt_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        idle_inputs();
        step();
        step();
        checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else passed++;
        checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want %0d", state, 0); else passed++;
        checks++; if (mepc !== 32'h0) $display("FAIL reset_mepc: got %h want %h", mepc, 32'h0); else passed++;
        checks++; if (mis_trap !== 1'b0) $display("FAIL reset_mis_trap: got %b want %b", mis_trap, 1'b0); else passed++;
        checks++; if (instret !== 32'h0) $display("FAIL reset_instret: got %h want %h", instret, 32'h0); else passed++;
        checks++; if (pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_boot();
        step();
        checks++; if (pc !== 32'h0) $display("FAIL boot_pc: got %h want %h", pc, 32'h0); else passed++;
        checks++; if (state !== 2'd1) $display("FAIL boot_state: got %0d want %0d", state, 1); else passed++;
        checks++; if (instret !== 32'h0) $display("FAIL boot_instret: got %h want %h", instret, 32'h0); else passed++;
        step();
        checks++; if (pc !== 32'h4) $display("FAIL run1_pc: got %h want %h", pc, 32'h4); else passed++;
        checks++; if (instret !== 32'h1) $display("FAIL run1_instret: got %h want %h", instret, 32'h1); else passed++;
        step();
        checks++; if (pc !== 32'h8) $display("FAIL run2_pc: got %h want %h", pc, 32'h8); else passed++;
        checks++; if (instret !== 32'h2) $display("FAIL run2_instret: got %h want %h", instret, 32'h2); else passed++;
    endtask

    task automatic test_branch_priority();
        // 0x8 + 0x18 = 0x20
        PC_SRC = 1'b1; imm = 32'h18;
        step();
        checks++; if (pc !== 32'h20) $display("FAIL branch_to_20: got %h want %h", pc, 32'h20); else passed++;
        imm = 32'h10;
        step();
        checks++; if (pc !== 32'h30) $display("FAIL branch_to_30: got %h want %h", pc, 32'h30); else passed++;
        checks++; if (instret !== 32'h4) $display("FAIL branch_instret: got %h want %h", instret, 32'h4); else passed++;
        jalr = 1'b1; jal = 1'b1; PC_SRC = 1'b1; rs1_val = 32'h1001; imm = 32'h4;
        step();
        checks++; if (pc !== 32'h1004) $display("FAIL jalr_priority_pc: got %h want %h", pc, 32'h1004); else passed++;
        checks++; if (pc_plus4 !== 32'h1008) $display("FAIL jalr_pc_plus4: got %h want %h", pc_plus4, 32'h1008); else passed++;
        checks++; if (instret !== 32'h5) $display("FAIL jalr_instret: got %h want %h", instret, 32'h5); else passed++;
        idle_inputs();
    endtask

    task automatic test_misaligned_trap();
        jalr = 1'b1; rs1_val = 32'h40; imm = 32'h0;
        step();
        checks++; if (pc !== 32'h40) $display("FAIL jalr_to_40: got %h want %h", pc, 32'h40); else passed++;
        idle_inputs();
        jal = 1'b1; imm = 32'h6;
        step();
        checks++; if (pc !== 32'h100) $display("FAIL trap_pc: got %h want %h", pc, 32'h100); else passed++;
        checks++; if (mepc !== 32'h40) $display("FAIL trap_mepc: got %h want %h", mepc, 32'h40); else passed++;
        checks++; if (state !== 2'd2) $display("FAIL trap_state: got %0d want %0d", state, 2); else passed++;
        checks++; if (mis_trap !== 1'b1) $display("FAIL trap_pulse: got %b want %b", mis_trap, 1'b1); else passed++;
        checks++; if (instret !== 32'h6) $display("FAIL trap_instret: got %h want %h", instret, 32'h6); else passed++;
        // jal stays asserted: TRAP flush cycle must ignore it
        step();
        checks++; if (state !== 2'd1) $display("FAIL flush_state: got %0d want %0d", state, 1); else passed++;
        checks++; if (pc !== 32'h100) $display("FAIL flush_pc: got %h want %h", pc, 32'h100); else passed++;
        checks++; if (mis_trap !== 1'b0) $display("FAIL flush_pulse_end: got %b want %b", mis_trap, 1'b0); else passed++;
        idle_inputs();
        step();
        checks++; if (pc !== 32'h104) $display("FAIL post_trap_pc: got %h want %h", pc, 32'h104); else passed++;
        checks++; if (instret !== 32'h7) $display("FAIL post_trap_instret: got %h want %h", instret, 32'h7); else passed++;
    endtask

    task automatic test_stall();
        en = 1'b0; imm = 32'h10;
        for (int i = 0; i < 5; i++) begin
            PC_SRC = ~PC_SRC;
            step();
            checks++; if (pc !== 32'h104) $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, 32'h104); else passed++;
            checks++; if (instret !== 32'h7) $display("FAIL stall_instret[%0d]: got %h want %h", i, instret, 32'h7); else passed++;
        end
        checks++; if (mepc !== 32'h40) $display("FAIL stall_mepc: got %h want %h", mepc, 32'h40); else passed++;
        idle_inputs();
        en = 1'b1;
    endtask

    task automatic test_trap_then_halt();
        jalr = 1'b1; rs1_val = 32'h102; halt_req = 1'b1;
        step();
        checks++; if (state !== 2'd2) $display("FAIL trap_over_halt_state: got %0d want %0d", state, 2); else passed++;
        checks++; if (mepc !== 32'h104) $display("FAIL trap_over_halt_mepc: got %h want %h", mepc, 32'h104); else passed++;
        checks++; if (pc !== 32'h100) $display("FAIL trap_over_halt_pc: got %h want %h", pc, 32'h100); else passed++;
        idle_inputs();
        step();
        jalr = 1'b1; rs1_val = 32'h200;
        step();
        checks++; if (pc !== 32'h200) $display("FAIL jalr_to_200: got %h want %h", pc, 32'h200); else passed++;
        checks++; if (instret !== 32'h8) $display("FAIL pre_halt_instret: got %h want %h", instret, 32'h8); else passed++;
        idle_inputs();
        halt_req = 1'b1;
        step();
        checks++; if (state !== 2'd3) $display("FAIL halt_state: got %0d want %0d", state, 3); else passed++;
        halt_req = 1'b0; imm = 32'h8;
        for (int i = 0; i < 10; i++) begin
            jal    = i[0];
            PC_SRC = ~i[0];
            step();
            checks++; if (pc !== 32'h200) $display("FAIL halted_pc[%0d]: got %h want %h", i, pc, 32'h200); else passed++;
        end
        checks++; if (state !== 2'd3) $display("FAIL halted_state_end: got %0d want %0d", state, 3); else passed++;
        checks++; if (instret !== 32'h8) $display("FAIL halted_instret: got %h want %h", instret, 32'h8); else passed++;
        checks++; if (pc_plus4 !== 32'h204) $display("FAIL halted_pc_plus4: got %h want %h", pc_plus4, 32'h204); else passed++;
        idle_inputs();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0) $display("FAIL async_rst_pc: got %h want %h", pc, 32'h0); else passed++;
        checks++; if (state !== 2'd0) $display("FAIL async_rst_state: got %0d want %0d", state, 0); else passed++;
        checks++; if (instret !== 32'h0) $display("FAIL async_rst_instret: got %h want %h", instret, 32'h0); else passed++;
        checks++; if (mepc !== 32'h0) $display("FAIL async_rst_mepc: got %h want %h", mepc, 32'h0); else passed++;
        step();
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        step();
        jalr = 1'b1; rs1_val = 32'hFFFF_FFFC;
        step();
        checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup_pc: got %h want %h", pc, 32'hFFFF_FFFC); else passed++;
        checks++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4: got %h want %h", pc_plus4, 32'h0); else passed++;
        idle_inputs();
        en = 1'b0;
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        en = 1'b1;
        step();
        checks++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); else passed++;
        checks++; if (instret !== 32'h0) $display("FAIL wrap_instret: got %h want %h", instret, 32'h0); else passed++;
        checks++; if (state !== 2'd1) $display("FAIL wrap_state: got %0d want %0d", state, 1); else passed++;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_branch_priority();
        test_misaligned_trap();
        test_stall();
        test_trap_then_halt();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Sequential program-counter unit for the single-cycle RV32I core.
- Consumes the branch-taken decision (PC_SRC) from the branch gate, plus the jump controls from decode.
- Owns the PC register, selects the next PC, detects misaligned targets and redirects to a trap vector.
- Keeps a retired-instruction counter and supports a halt state for FPGA debug.

Parameters:
- XLEN, 32, datapath width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target trap.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 freezes all state.
- PC_SRC  input  1  conditional branch taken (Branch & Zero).
- jal  input  1  current instruction is JAL.
- jalr  input  1  current instruction is JALR.
- imm  input  XLEN  sign-extended immediate.
- rs1_val  input  XLEN  register rs1 value (JALR base).
- halt_req  input  1  current instruction requests halt (EBREAK).
- pc  output  XLEN  current PC, registered.
- pc_plus4  output  XLEN  pc+4, combinational, used as the link value.
- mepc  output  XLEN  PC of the last faulting instruction, registered.
- mis_trap  output  1  one-cycle registered pulse after a trap is taken.
- state  output  2  FSM state: 0 BOOT, 1 RUN, 2 TRAP, 3 HALTED.
- instret  output  XLEN  retired-instruction count, registered.

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_VECTOR, state=BOOT, mepc=0, mis_trap=0, instret=0.
  - Reset asserted mid-operation overrides everything immediately.
- Target select (combinational, priority highest first):
  - jalr: (rs1_val+imm) with bit0 forced to 0.
  - jal: pc+imm.
  - PC_SRC: pc+imm.
  - otherwise: pc+4.
  - Addition is modulo 2^XLEN; wrap-around is not flagged.
- Misaligned: selected target bit1 != 0. After JALR bit0 clearing only bit1 matters; pc+4 is always aligned if pc is aligned.
- mis_trap defaults to 0 every cycle unless set by the TRAP entry rule below.
- en=0: pc, mepc, instret and state all hold, in every state.
- BOOT:
  - Lasts exactly one cycle with en=1; pc holds RESET_VECTOR; no retire.
  - Then moves to RUN.
- RUN with en=1, misaligned target (highest priority, beats halt_req):
  - mepc<=pc, pc<=TRAP_VECTOR, state<=TRAP.
  - instret unchanged; mis_trap=1 on the next cycle.
- RUN with en=1, halt_req=1, target aligned:
  - pc holds, instret unchanged, state<=HALTED.
- RUN with en=1, otherwise:
  - pc<=target; instret<=instret+1, wrapping 0xFFFF_FFFF -> 0.
- TRAP:
  - One cycle with en=1 acting as a flush: pc holds TRAP_VECTOR, inputs ignored, no retire.
  - Then moves to RUN.
  - mis_trap is 1 during this cycle only.
- HALTED: pc, mepc, instret frozen; all inputs ignored; exit only via rst.
- Latency: a target selected at a rising edge is visible on pc immediately after that edge, i.e. single-cycle next-PC.
- Illegal state encoding cannot occur; if reached, recover to BOOT at the next en=1 edge.
- pc_plus4 always equals pc+4, including in BOOT, TRAP and HALTED.

Test Plan:
- Reset and boot:
  - Stimulus: rst pulse, en=1, no controls.
  - Required: pc=0x0 through BOOT; then pc=0x4, 0x8; instret=1, 2; state goes 0 -> 1.
- Branch vs JALR priority:
  - Stimulus: pc=0x20, PC_SRC=1, imm=0x10 -> pc=0x30. Then jalr=1, jal=1, PC_SRC=1, rs1_val=0x1001, imm=0x4.
  - Required: pc=0x1004, since jalr wins and bit0 is cleared.
- Misaligned trap:
  - Stimulus: pc=0x40, jal=1, imm=0x6.
  - Required: pc=0x100, mepc=0x40, state=TRAP for one cycle with mis_trap=1; then RUN and pc=0x104; instret does not count the faulting jal.
- Trap beats halt, then halt:
  - Stimulus: misaligned jalr with halt_req=1 -> trap is taken. Later, aligned halt_req=1 at pc=0x200.
  - Required: state=HALTED, pc stays 0x200 for 10 cycles despite jal/PC_SRC toggling.
- Enable stall and async reset:
  - Stimulus: en=0 for 5 cycles while PC_SRC toggles; then rst asserted between clock edges.
  - Required: during the stall, pc and instret are unchanged. On rst, pc=0x0 and state=BOOT immediately, without waiting for an edge.
- Counter and address wrap:
  - Stimulus: force instret=0xFFFF_FFFF, pc=0xFFFF_FFFC, one normal retire.
  - Required: instret=0 and pc=0x0.
